// File: rtl/stacker_core_if.sv
// Player/scanner-facing bundle of the stacker game engine.
// master: the engine; slave: debouncer, scanner, score and sound side.
interface stacker_core_if #(
    parameter int COLS = 8,
    parameter int ROWS = 8
);
    logic                         drop;
    logic [$clog2(ROWS)-1:0]      scan_row;
    logic [COLS-1:0]              scan_bits;
    logic [$clog2(ROWS+1)-1:0]    level;
    logic [1:0]                   state;
    logic [$clog2(COLS+1)-1:0]    width;
    logic                         flash;
    logic                         sound;
    logic                         win_pulse;
    logic                         lose_pulse;

    modport master (
        input  drop, scan_row,
        output scan_bits, level, state, width,
        output flash, sound, win_pulse, lose_pulse
    );

    modport slave (
        output drop, scan_row,
        input  scan_bits, level, state, width,
        input  flash, sound, win_pulse, lose_pulse
    );
endinterface

// File: rtl/stacker_core.sv
// Stacker game engine: bouncing block, trimming stack, per-level speed,
// timed win/lose display. Single clock, no derived clocks.
module stacker_core #(
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int START_WIDTH  = 3,
    parameter int TICK_BASE    = 25_000_000,
    parameter int TICK_STEP    = 2_500_000,
    parameter int TICK_MIN     = 2_000_000,
    parameter int END_CYCLES   = 100_000_000,
    parameter int FLASH_CYCLES = 12_500_000
) (
    input  logic          clk,
    input  logic          reset_n,
    stacker_core_if.master bus
);
    localparam int RW = $clog2(ROWS);
    localparam int LW = $clog2(ROWS + 1);
    localparam int WW = $clog2(COLS + 1);
    localparam bit ROW_POW2 = (ROWS == (1 << RW));
    localparam logic [COLS:0] ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic            r_drop_q;
    logic [LW-1:0]   r_level;
    logic [WW-1:0]   r_width;
    logic [WW-1:0]   r_pos;
    logic            r_dir_dn;
    logic [31:0]     r_tick, r_end, r_fcnt;
    logic            r_flash;
    logic [COLS-1:0] r_stack [ROWS];
    logic [COLS-1:0] r_scan;
    logic            r_win_p, r_lose_p;

    logic            w_ev, w_row_ok, w_last, w_tc, w_end_tc, w_fl_tc;
    logic [COLS:0]   w_mask_x;
    logic [COLS-1:0] w_mask, w_prev, w_ov, w_scan;
    logic [WW-1:0]   w_ov_w, w_span, w_new_span, w_step;
    logic [31:0]     w_prod, w_period;

    assign w_ev       = bus.drop & ~r_drop_q;
    assign w_mask_x   = ((ONE << r_width) - ONE) << r_pos;
    assign w_mask     = w_mask_x[COLS-1:0];
    assign w_prev     = r_stack[RW'(r_level - LW'(1))];
    assign w_ov       = (r_level == '0) ? w_mask : (w_mask & w_prev);
    assign w_ov_w     = WW'($countones(w_ov));
    assign w_span     = WW'(COLS) - r_width;
    assign w_new_span = WW'(COLS) - w_ov_w;
    assign w_step     = r_dir_dn ? r_pos - WW'(1) : r_pos + WW'(1);
    assign w_last     = (r_level == LW'(ROWS - 1));

    // Step period shrinks per level but saturates at TICK_MIN
    assign w_prod   = 32'(r_level) * 32'(TICK_STEP);
    assign w_period = (32'(TICK_BASE) > w_prod &&
                       32'(TICK_BASE) - w_prod > 32'(TICK_MIN))
                    ? 32'(TICK_BASE) - w_prod : 32'(TICK_MIN);
    assign w_tc     = (r_tick >= w_period - 32'd1);
    assign w_end_tc = (r_end == 32'(END_CYCLES - 1));
    assign w_fl_tc  = (r_fcnt == 32'(FLASH_CYCLES - 1));
    assign w_row_ok = ROW_POW2 || (32'(bus.scan_row) < 32'(ROWS));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_ev) w_next = S_PLAY;
            S_PLAY: begin
                if (w_ev) begin
                    if (w_ov == '0)  w_next = S_LOSE;
                    else if (w_last) w_next = S_WIN;
                end
            end
            S_WIN, S_LOSE: if (w_end_tc) w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_scan = '0;
        unique case (1'b1)
            w_row_ok && r_state == S_PLAY:
                w_scan = r_stack[bus.scan_row] |
                         ((LW'(bus.scan_row) == r_level) ? w_mask : '0);
            w_row_ok && r_state == S_WIN:
                w_scan = {COLS{r_flash}};
            w_row_ok && r_state == S_LOSE:
                w_scan = r_flash ? r_stack[bus.scan_row] : '0;
            default: w_scan = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_q <= 1'b0;
            r_level  <= '0;
            r_width  <= WW'(START_WIDTH);
            r_pos    <= '0;
            r_dir_dn <= 1'b1;
            r_tick   <= '0;
            r_end    <= '0;
            r_fcnt   <= '0;
            r_flash  <= 1'b0;
            r_scan   <= '0;
            r_win_p  <= 1'b0;
            r_lose_p <= 1'b0;
            for (int i = 0; i < ROWS; i++) r_stack[i] <= '0;
        end else begin
            r_drop_q <= bus.drop;
            r_scan   <= w_scan;
            r_win_p  <= (r_state == S_PLAY) && (w_next == S_WIN);
            r_lose_p <= (r_state == S_PLAY) && (w_next == S_LOSE);
            unique case (r_state)
                S_IDLE: begin
                    r_level <= '0;
                    r_width <= WW'(START_WIDTH);
                    r_flash <= 1'b0;
                    for (int i = 0; i < ROWS; i++) r_stack[i] <= '0;
                    if (w_ev) begin
                        r_pos    <= WW'(COLS - START_WIDTH);
                        r_dir_dn <= 1'b1;
                        r_tick   <= '0;
                    end
                end
                S_PLAY: begin
                    if (w_ev) begin
                        // A same-cycle tick is dropped: the drop sees the pre-step pos
                        if (w_ov != '0) begin
                            r_stack[RW'(r_level)] <= w_ov;
                            r_width  <= w_ov_w;
                            r_level  <= r_level + LW'(1);
                            r_pos    <= w_new_span;
                            r_dir_dn <= 1'b1;
                            r_tick   <= '0;
                        end
                        if (w_next != S_PLAY) begin
                            r_end   <= '0;
                            r_fcnt  <= '0;
                            r_flash <= 1'b1;
                        end
                    end else if (w_tc) begin
                        r_tick <= '0;
                        if (w_span != '0) begin
                            r_pos <= w_step;
                            if (w_step == '0)     r_dir_dn <= 1'b0;
                            if (w_step == w_span) r_dir_dn <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 32'd1;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (w_end_tc) begin
                        r_level <= '0;
                        r_width <= WW'(START_WIDTH);
                        r_flash <= 1'b0;
                        for (int i = 0; i < ROWS; i++) r_stack[i] <= '0;
                    end else begin
                        r_end <= r_end + 32'd1;
                        if (w_fl_tc) begin
                            r_flash <= ~r_flash;
                            r_fcnt  <= '0;
                        end else begin
                            r_fcnt <= r_fcnt + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.scan_bits  = r_scan;
    assign bus.level      = r_level;
    assign bus.state      = r_state;
    assign bus.width      = r_width;
    assign bus.flash      = r_flash;
    assign bus.sound      = (r_state == S_WIN) || (r_state == S_LOSE);
    assign bus.win_pulse  = r_win_p;
    assign bus.lose_pulse = r_lose_p;
endmodule

// File: tb/tb_stacker_core.sv
// Bench for stacker_core: time-based game model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_stacker_core;
    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int SW    = 3;
    localparam int TBASE = 4;
    localparam int TSTEP = 1;
    localparam int TMIN  = 2;
    localparam int ENDC  = 20;
    localparam int FC    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stacker_core_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    stacker_core #(
        .COLS(COLS), .ROWS(ROWS), .START_WIDTH(SW),
        .TICK_BASE(TBASE), .TICK_STEP(TSTEP), .TICK_MIN(TMIN),
        .END_CYCLES(ENDC), .FLASH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: game state plus cycles elapsed since the current level / end
    // state began; block position and flash phase are derived from time.
    int m_state = 0;
    int m_level = 0;
    int m_width = SW;
    int m_t     = 0;
    int m_stack [ROWS];
    int m_scan  = 0;
    int m_winp  = 0;
    int m_losep = 0;
    bit m_dq    = 1'b0;
    int ev, msk, ov, row, v;

    function automatic int period(input int lv);
        int p;
        p = TBASE - lv * TSTEP;
        return (p > TMIN) ? p : TMIN;
    endfunction

    function automatic int bounce(input int k, input int span);
        int r;
        if (span == 0) return 0;
        r = k % (2 * span);
        return (r <= span) ? span - r : r - span;
    endfunction

    function automatic int maskof(input int w, input int p);
        return (((1 << w) - 1) << p) & ((1 << COLS) - 1);
    endfunction

    function automatic int mpos();
        return bounce(m_t / period(m_level), COLS - m_width);
    endfunction

    function automatic int mflash();
        if (m_state < 2) return 0;
        return ((m_t / FC) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic m_new_game();
        m_state = 0;
        m_level = 0;
        m_width = SW;
        m_t     = 0;
        for (int i = 0; i < ROWS; i++) m_stack[i] = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_new_game();
            m_dq = 1'b0; m_scan = 0; m_winp = 0; m_losep = 0;
        end else begin
            ev   = (bus.drop === 1'b1 && !m_dq) ? 1 : 0;
            m_dq = (bus.drop === 1'b1);
            row  = int'(bus.scan_row);
            v    = 0;
            if (m_state == 1) begin
                v = m_stack[row];
                if (row == m_level) v = v | maskof(m_width, mpos());
            end else if (m_state == 2) begin
                v = (mflash() != 0) ? (1 << COLS) - 1 : 0;
            end else if (m_state == 3) begin
                v = (mflash() != 0) ? m_stack[row] : 0;
            end
            m_scan = v; m_winp = 0; m_losep = 0;
            case (m_state)
                0: if (ev != 0) begin m_state = 1; m_t = 0; end
                1: begin
                    if (ev != 0) begin
                        msk = maskof(m_width, mpos());
                        if (m_level == 0) ov = msk;
                        else              ov = msk & m_stack[m_level-1];
                        m_t = 0;
                        if (ov == 0) begin
                            m_state = 3; m_losep = 1;
                        end else begin
                            m_stack[m_level] = ov;
                            m_width = $countones(ov);
                            m_level++;
                            if (m_level == ROWS) begin m_state = 2; m_winp = 1; end
                        end
                    end else begin
                        m_t++;
                    end
                end
                default: begin
                    if (m_t == ENDC - 1) m_new_game();
                    else                 m_t++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(bus.state), m_state);
            chk("level", 32'(bus.level), m_level);
            chk("width", 32'(bus.width), m_width);
            chk("flash", 32'(bus.flash), mflash());
            chk("sound", 32'(bus.sound), (m_state >= 2) ? 1 : 0);
            chk("win_pulse", 32'(bus.win_pulse), m_winp);
            chk("lose_pulse", 32'(bus.lose_pulse), m_losep);
            chk("scan_bits", 32'(bus.scan_bits), m_scan);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        bus.drop = 1'b1;
        @(negedge clk);
        bus.drop = 1'b0;
    endtask

    task automatic async_reset(input string nm);
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_state"}, 32'(bus.state), 0);
        chk({nm, "_level"}, 32'(bus.level), 0);
        chk({nm, "_width"}, 32'(bus.width), SW);
        chk({nm, "_scan"}, 32'(bus.scan_bits), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] bexp [12];

    initial begin
        bexp = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07,
                 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};
        bus.drop = 1'b0;
        bus.scan_row = '0;
        cyc(3);
        cmp_en = 1'b1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_width", 32'(bus.width), 3);
        chk("rst_scan", 32'(bus.scan_bits), 0);
        chk("rst_flash", 32'(bus.flash), 0);
        chk("rst_sound", 32'(bus.sound), 0);
        rst_n = 1'b1;

        // Bounce at level 0: one step every 4 cycles
        press();
        cyc(2);
        for (int k = 0; k < 12; k++) begin
            chk("bounce", 32'(bus.scan_bits), int'(bexp[k]));
            cyc(4);
        end
        async_reset("midplay");

        // Start then drop immediately, then partial overlap at pos 4
        press();
        cyc(1);
        press();
        chk("first_level", 32'(bus.level), 1);
        chk("first_width", 32'(bus.width), 3);
        bus.scan_row = 2'd1;
        cyc(1);
        chk("first_row1", 32'(bus.scan_bits), 32'hE0);
        cyc(2);
        press();
        chk("trim_width", 32'(bus.width), 2);
        chk("trim_level", 32'(bus.level), 2);
        bus.scan_row = 2'd1;
        cyc(1);
        chk("trim_row1", 32'(bus.scan_bits), 32'h60);
        bus.scan_row = 2'd2;
        cyc(1);
        chk("trim_newpos", 32'(bus.scan_bits), 32'hC0);

        // Full miss at pos 3 (0x18 vs 0x60)
        cyc(4);
        press();
        chk("miss_pulse", 32'(bus.lose_pulse), 1);
        chk("miss_state", 32'(bus.state), 3);
        chk("miss_sound", 32'(bus.sound), 1);
        bus.scan_row = 2'd1;
        cyc(1);
        chk("miss_pulse_end", 32'(bus.lose_pulse), 0);
        chk("miss_scan", 32'(bus.scan_bits), 32'h60);
        cyc(18);
        chk("lose_last", 32'(bus.state), 3);
        cyc(1);
        chk("lose_idle", 32'(bus.state), 0);
        cyc(1);
        chk("idle_scan", 32'(bus.scan_bits), 0);

        // Held drop gives exactly one event
        bus.drop = 1'b1;
        cyc(50);
        bus.drop = 1'b0;
        chk("held_state", 32'(bus.state), 1);
        chk("held_level", 32'(bus.level), 0);
        async_reset("held");

        // Drop on the tick edge uses the pre-step pos 5
        press();
        cyc(3);
        press();
        bus.scan_row = 2'd0;
        cyc(1);
        chk("tick_drop", 32'(bus.scan_bits), 32'hE0);
        chk("tick_level", 32'(bus.level), 1);
        async_reset("tick");

        // Perfect game
        press();
        for (int d = 0; d < ROWS; d++) begin
            cyc(1);
            press();
        end
        chk("win_pulse", 32'(bus.win_pulse), 1);
        chk("win_state", 32'(bus.state), 2);
        chk("win_level", 32'(bus.level), 4);
        bus.scan_row = 2'd0;
        cyc(1);
        chk("win_ff", 32'(bus.scan_bits), 32'hFF);
        cyc(3);
        chk("win_00", 32'(bus.scan_bits), 32'h00);
        cyc(3);
        chk("win_ff2", 32'(bus.scan_bits), 32'hFF);
        cyc(13);
        chk("win_idle", 32'(bus.state), 0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
